// File: rtl/alu_pipe_flags.sv
// Two-stage pipelined ALU with registered flags and valid/ready handshakes on both sides.
// 2-cycle latency, 1 beat/cycle; a stalled output holds result/flags and drops in_ready once both stages are full.
module alu_pipe_flags #(
   parameter int WIDTH   = 16,
   parameter int SHIFT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         opcode,
   input  logic [WIDTH-1:0]   input1,
   input  logic [WIDTH-1:0]   input2,
   input  logic [SHIFT_W-1:0] shiftValue,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result,
   output logic               carryFlag,
   output logic               zeroFlag,
   output logic               overFlowFlag,
   output logic               signFlag
);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_SLL = 4'd4;
   localparam logic [3:0] OP_SRA = 4'd5;
   localparam logic [3:0] OP_XOR = 4'd6;
   localparam logic [3:0] OP_SRL = 4'd7;
   localparam logic [3:0] OP_ADC = 4'd8;

   logic               valid_a;
   logic [3:0]         op_a;
   logic [WIDTH-1:0]   a_a;
   logic [WIDTH-1:0]   b_a;
   logic [SHIFT_W-1:0] sh_a;
   logic               cstate;

   logic adv_a;
   logic adv_b;

   logic [WIDTH:0]     sum_w;
   logic [WIDTH:0]     diff_w;
   logic [WIDTH:0]     sll_w;
   logic [WIDTH:0]     srl_w;
   logic [WIDTH:0]     sra_w;
   logic               cin;
   logic [WIDTH-1:0]   res_n;
   logic               carry_n;
   logic               ovf_n;
   logic               upd_cstate;

   assign adv_b    = !out_valid || out_ready;
   assign adv_a    = !valid_a || adv_b;
   assign in_ready = adv_a;

   always_comb begin
      cin        = (op_a == OP_ADC) ? cstate : 1'b0;
      sum_w      = {1'b0, a_a} + {1'b0, b_a} + {{WIDTH{1'b0}}, cin};
      diff_w     = {1'b0, a_a} - {1'b0, b_a};
      // Extra bit on the shifted-out side captures the last bit lost; zero for a shift of 0.
      sll_w      = {1'b0, a_a} << sh_a;
      srl_w      = {a_a, 1'b0} >> sh_a;
      sra_w      = $signed({a_a, 1'b0}) >>> sh_a;
      res_n      = '0;
      carry_n    = 1'b0;
      ovf_n      = 1'b0;
      upd_cstate = 1'b0;
      case (op_a)
         OP_ADD, OP_ADC: begin
            res_n      = sum_w[WIDTH-1:0];
            carry_n    = sum_w[WIDTH];
            ovf_n      = (a_a[WIDTH-1] == b_a[WIDTH-1]) && (res_n[WIDTH-1] != a_a[WIDTH-1]);
            upd_cstate = 1'b1;
         end
         OP_SUB: begin
            res_n      = diff_w[WIDTH-1:0];
            carry_n    = diff_w[WIDTH];
            ovf_n      = (a_a[WIDTH-1] != b_a[WIDTH-1]) && (res_n[WIDTH-1] != a_a[WIDTH-1]);
            upd_cstate = 1'b1;
         end
         OP_AND: res_n = a_a & b_a;
         OP_OR:  res_n = a_a | b_a;
         OP_XOR: res_n = a_a ^ b_a;
         OP_SLL: begin
            res_n   = sll_w[WIDTH-1:0];
            carry_n = sll_w[WIDTH];
         end
         OP_SRL: begin
            res_n   = srl_w[WIDTH:1];
            carry_n = srl_w[0];
         end
         OP_SRA: begin
            res_n   = sra_w[WIDTH:1];
            carry_n = sra_w[0];
         end
         default: begin
            res_n = '0;
         end
      endcase
   end

   // cstate follows stage-B loads, so an ADC in stage A always sees its predecessor's carry.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_a      <= 1'b0;
         op_a         <= '0;
         a_a          <= '0;
         b_a          <= '0;
         sh_a         <= '0;
         cstate       <= 1'b0;
         out_valid    <= 1'b0;
         result       <= '0;
         carryFlag    <= 1'b0;
         zeroFlag     <= 1'b0;
         overFlowFlag <= 1'b0;
         signFlag     <= 1'b0;
      end else begin
         if (adv_b) begin
            out_valid <= valid_a;
            if (valid_a) begin
               result       <= res_n;
               carryFlag    <= carry_n;
               zeroFlag     <= (res_n == '0);
               overFlowFlag <= ovf_n;
               signFlag     <= res_n[WIDTH-1];
               if (upd_cstate) begin
                  cstate <= carry_n;
               end
            end
         end
         if (adv_a) begin
            valid_a <= in_valid;
            if (in_valid) begin
               op_a <= opcode;
               a_a  <= input1;
               b_a  <= input2;
               sh_a <= shiftValue;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_pipe_flags.sv
// Bench for alu_pipe_flags: directed plan steps then random traffic with backpressure,
// scored against an arithmetic reference model queued in program order.
module tb_alu_pipe_flags;

   typedef struct packed {
      logic [15:0] r;
      logic        c;
      logic        z;
      logic        v;
      logic        n;
   } res_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  opcode;
   logic [15:0] input1;
   logic [15:0] input2;
   logic [3:0]  shiftValue;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic        carryFlag;
   logic        zeroFlag;
   logic        overFlowFlag;
   logic        signFlag;

   int   checks = 0;
   int   errors = 0;
   res_t exp_q[$];
   res_t ret_q[$];
   bit   m_cs = 1'b0;
   bit   prev_stall = 1'b0;
   res_t prev_obs;

   always #5 clk = ~clk;

   alu_pipe_flags #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .input1(input1), .input2(input2), .shiftValue(shiftValue),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .carryFlag(carryFlag), .zeroFlag(zeroFlag),
      .overFlowFlag(overFlowFlag), .signFlag(signFlag)
   );

   // Reference: plain integer arithmetic on zero-extended operands.
   function automatic res_t model(input int op, input int a, input int b, input int s, input bit cs);
      res_t x;
      int   full;
      int   sa;
      x = '0;
      case (op)
         0, 8: begin
            full = a + b + ((op == 8) ? int'(cs) : 0);
            x.r  = full[15:0];
            x.c  = full[16];
            x.v  = (a[15] == b[15]) && (x.r[15] != a[15]);
         end
         1: begin
            full = a - b;
            x.r  = full[15:0];
            x.c  = (a < b);
            x.v  = (a[15] != b[15]) && (x.r[15] != a[15]);
         end
         2: x.r = 16'(a & b);
         3: x.r = 16'(a | b);
         6: x.r = 16'(a ^ b);
         4: begin
            full = a << s;
            x.r  = full[15:0];
            x.c  = (s != 0) && (full[16] == 1'b1);
         end
         7: begin
            x.r = 16'(a >> s);
            x.c = (s != 0) && (((a >> (s - 1)) & 1) != 0);
         end
         5: begin
            sa  = (a >= 32768) ? a - 65536 : a;
            x.r = 16'(sa >>> s);
            x.c = (s != 0) && (((sa >>> (s - 1)) & 1) != 0);
         end
         default: x.r = 16'h0000;
      endcase
      x.z = (x.r == 16'h0000);
      x.n = x.r[15];
      return x;
   endfunction

   task automatic step(input bit iv, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] s, input bit ordy, output bit acc, output bit ret);
      res_t obs;
      res_t e;
      @(negedge clk);
      in_valid = iv; opcode = op; input1 = a; input2 = b; shiftValue = s; out_ready = ordy;
      #1;
      obs = {result, carryFlag, zeroFlag, overFlowFlag, signFlag};
      acc = (in_valid && in_ready === 1'b1);
      ret = (out_valid === 1'b1) && out_ready;
      if (prev_stall) begin
         checks++;
         assert (out_valid === 1'b1 && obs === prev_obs)
            else begin errors++; $error("FAIL hold obs=%h vld=%b exp=%h", obs, out_valid, prev_obs); end
      end
      if (out_valid === 1'b1) begin
         checks++;
         assert (exp_q.size() > 0)
            else begin errors++; $error("FAIL spurious_out obs=%h exp=none", obs); end
         if (exp_q.size() > 0) begin
            e = exp_q[0];
            checks++;
            assert (obs === e)
               else begin errors++; $error("FAIL out obs=%h exp=%h", obs, e); end
            if (ret) begin
               void'(exp_q.pop_front());
               ret_q.push_back(obs);
            end
         end
      end
      prev_stall = (out_valid === 1'b1) && !ordy;
      prev_obs   = obs;
      if (acc) begin
         e = model(int'(op), int'(a), int'(b), int'(s), m_cs);
         if (op == 4'd0 || op == 4'd1 || op == 4'd8) m_cs = e.c;
         exp_q.push_back(e);
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic [3:0] s);
      bit ac, rt;
      step(1'b1, op, a, b, s, 1'b1, ac, rt);
      checks++;
      assert (ac) else begin errors++; $error("FAIL accept obs=%b exp=1", ac); end
   endtask

   task automatic drain();
      bit ac, rt;
      int n = 0;
      while (exp_q.size() > 0 && n < 30) begin
         step(1'b0, 4'd0, 16'h0, 16'h0, 4'd0, 1'b1, ac, rt);
         n++;
      end
      checks++;
      assert (exp_q.size() == 0)
         else begin errors++; $error("FAIL drain_timeout obs=%0d pending exp=0", exp_q.size()); end
   endtask

   task automatic expect_ret(input int idx, input res_t e, input string tag);
      res_t obs;
      obs = (idx < ret_q.size()) ? ret_q[idx] : 'x;
      checks++;
      assert (obs === e) else begin errors++; $error("FAIL %s obs=%h exp=%h", tag, obs, e); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ac, rt;
      int idx;
      int nret;
      res_t obs;
      rst = 1'b1; in_valid = 1'b0; opcode = '0; input1 = '0; input2 = '0; shiftValue = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      obs = {result, carryFlag, zeroFlag, overFlowFlag, signFlag};
      checks++;
      assert (out_valid === 1'b0 && obs === res_t'(0))
         else begin errors++; $error("FAIL reset_out obs=%b/%h exp=0/0", out_valid, obs); end
      checks++;
      assert (in_ready === 1'b1) else begin errors++; $error("FAIL reset_in_ready obs=%b exp=1", in_ready); end

      // Latency: accepted at N, visible at N+2.
      ret_q.delete();
      issue(4'd0, 16'hFFFF, 16'h0001, 4'd0);
      step(1'b0, 4'd0, 16'h0, 16'h0, 4'd0, 1'b1, ac, rt);
      checks++;
      assert (out_valid === 1'b0) else begin errors++; $error("FAIL lat_n1 obs=%b exp=0", out_valid); end
      step(1'b0, 4'd0, 16'h0, 16'h0, 4'd0, 1'b1, ac, rt);
      checks++;
      assert (rt) else begin errors++; $error("FAIL lat_n2 obs=%b exp=1", rt); end
      expect_ret(0, {16'h0000, 1'b1, 1'b1, 1'b0, 1'b0}, "add_wrap");

      ret_q.delete();
      issue(4'd0, 16'h7FFF, 16'h0001, 4'd0);
      issue(4'd8, 16'h0000, 16'h0000, 4'd0);
      drain();
      expect_ret(0, {16'h8000, 1'b0, 1'b0, 1'b1, 1'b1}, "add_ovf");
      expect_ret(1, {16'h0000, 1'b0, 1'b1, 1'b0, 1'b0}, "adc_zero");

      ret_q.delete();
      issue(4'd0, 16'hFFFF, 16'h0002, 4'd0);
      issue(4'd8, 16'h0001, 16'h0001, 4'd0);
      drain();
      expect_ret(1, {16'h0003, 1'b0, 1'b0, 1'b0, 1'b0}, "adc_chain");

      ret_q.delete();
      issue(4'd1, 16'h0003, 16'h0005, 4'd0);
      issue(4'd5, 16'h8001, 16'h0000, 4'd1);
      issue(4'd7, 16'h8001, 16'h0000, 4'd15);
      issue(4'd4, 16'h8001, 16'h0000, 4'd1);
      issue(4'd4, 16'h8001, 16'h0000, 4'd0);
      issue(4'd12, 16'h1234, 16'h5678, 4'd3);
      drain();
      expect_ret(0, {16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1}, "sub_borrow");
      expect_ret(1, {16'hC000, 1'b1, 1'b0, 1'b0, 1'b1}, "sra1");
      expect_ret(2, {16'h0001, 1'b0, 1'b0, 1'b0, 1'b0}, "srl15");
      expect_ret(3, {16'h0002, 1'b1, 1'b0, 1'b0, 1'b0}, "sll1");
      expect_ret(4, {16'h8001, 1'b0, 1'b0, 1'b0, 1'b1}, "shift0");
      expect_ret(5, {16'h0000, 1'b0, 1'b1, 1'b0, 1'b0}, "illegal_op");

      // Backpressure: 4 beats against a stalled sink.
      idx = 0;
      for (int c = 0; c < 6; c++) begin
         step(idx < 4, 4'd0, 16'(idx + 1), 16'h0010, 4'd0, 1'b0, ac, rt);
         if (ac) idx++;
      end
      checks++;
      assert (idx == 2) else begin errors++; $error("FAIL bp_accepted obs=%0d exp=2", idx); end
      checks++;
      assert (in_ready === 1'b0) else begin errors++; $error("FAIL bp_in_ready obs=%b exp=0", in_ready); end
      ret_q.delete();
      nret = 0;
      for (int c = 0; c < 4; c++) begin
         step(idx < 4, 4'd0, 16'(idx + 1), 16'h0010, 4'd0, 1'b1, ac, rt);
         if (ac) idx++;
         if (rt) nret++;
      end
      checks++;
      assert (nret == 4) else begin errors++; $error("FAIL bp_retire_rate obs=%0d exp=4", nret); end
      expect_ret(3, {16'h0014, 1'b0, 1'b0, 1'b0, 1'b0}, "bp_order");

      // Reset with carry set and two beats in flight.
      issue(4'd0, 16'hFFFF, 16'hFFFF, 4'd0);
      issue(4'd0, 16'hFFFF, 16'hFFFF, 4'd0);
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      assert (out_valid === 1'b0 && in_ready === 1'b1)
         else begin errors++; $error("FAIL rst_flush obs=%b%b exp=01", out_valid, in_ready); end
      exp_q.delete();
      m_cs = 1'b0;
      prev_stall = 1'b0;
      ret_q.delete();
      issue(4'd8, 16'h0001, 16'h0001, 4'd0);
      drain();
      expect_ret(0, {16'h0002, 1'b0, 1'b0, 1'b0, 1'b0}, "rst_cstate");

      // Random traffic with random backpressure, ADC-heavy to exercise carry chaining.
      for (int c = 0; c < 600; c++) begin
         logic [3:0] rop;
         rop = ($urandom % 3 == 0) ? 4'd8 : 4'($urandom % 16);
         step(($urandom % 4) != 0, rop, 16'($urandom), 16'($urandom), 4'($urandom),
              ($urandom % 4) != 0, ac, rt);
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
